// File: rtl/pin_keypad_collector.sv
// pin_keypad_collector: assembles four BCD keystrokes into a 16-bit PIN word
// (first digit in [15:12]) and strobes pin_valid on ENTER. Entry is enabled
// only while a vehicle is present and a partial entry is dropped after
// TIMEOUT_CYCLES cycles without a keystroke.
module pin_keypad_collector #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sensor_vehicule,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] password_input,
    output logic        pin_valid,
    output logic [2:0]  digit_count,
    output logic        entry_error,
    output logic        entry_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [3:0]       KEY_CLEAR = 4'hA;
    localparam logic [3:0]       KEY_ENTER = 4'hB;
    // Last counter value before the timeout fires; the counter never
    // reaches TIMEOUT_CYCLES itself.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [15:0]       buf_q, buf_d;
    logic [15:0]       pw_q, pw_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic              pv_q, pv_d;
    logic              err_q, err_d;
    logic              to_q, to_d;

    // State and registered outputs; reset also kills any pending pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            pw_q    <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            pv_q    <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pw_q    <= pw_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            pv_q    <= pv_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    // Next-state: sensor drop beats any key, a key beats the inactivity timeout.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pw_d    = pw_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        pv_d    = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Keys are silently ignored until a vehicle shows up.
                if (sensor_vehicule) begin
                    state_d = COLLECT;
                    buf_d   = '0;
                    cnt_d   = '0;
                    idle_d  = '0;
                end
            end

            COLLECT, FULL: begin
                if (!sensor_vehicule) begin
                    state_d = IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                    pw_d    = '0;
                    idle_d  = '0;
                end else if (key_valid) begin
                    idle_d = '0;
                    if (key_code <= 4'd9) begin
                        if (state_q == FULL) begin
                            err_d = 1'b1;
                        end else begin
                            buf_d = {buf_q[11:0], key_code};
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_q == 3'd3) state_d = FULL;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        state_d = COLLECT;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end else if (key_code == KEY_ENTER) begin
                        if (state_q == FULL) begin
                            pw_d = buf_q;
                            pv_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = COLLECT;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q != 3'd0) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = COLLECT;
                        buf_d   = '0;
                        cnt_d   = '0;
                        idle_d  = '0;
                        to_d    = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end else begin
                    idle_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                buf_d   = '0;
                cnt_d   = '0;
                pw_d    = '0;
                idle_d  = '0;
            end
        endcase
    end

    assign password_input = pw_q;
    assign pin_valid      = pv_q;
    assign digit_count    = cnt_q;
    assign entry_error    = err_q;
    assign entry_timeout  = to_q;

endmodule

// File: tb/tb_pin_keypad_collector.sv
// Scoreboard bench for pin_keypad_collector: a digit-list model computes the
// expected outputs each clock, a monitor compares them half a cycle later.
module tb_pin_keypad_collector;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sensor_vehicule;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] password_input;
    logic        pin_valid;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        entry_timeout;

    pin_keypad_collector #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .sensor_vehicule (sensor_vehicule),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .password_input  (password_input),
        .pin_valid       (pin_valid),
        .digit_count     (digit_count),
        .entry_error     (entry_error),
        .entry_timeout   (entry_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pw;
        logic        pv;
        logic [2:0]  dc;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_pins = 0;

    // Reference model: entry active flag, list of typed digits, last PIN,
    // count of keyless cycles since the last key.
    bit   m_act;
    int   m_dig[$];
    int   m_pw;
    int   m_idle;

    initial begin
        exp_t e;
        int   v;
        m_act = 0; m_dig.delete(); m_pw = 0; m_idle = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_act = 0; m_dig.delete(); m_pw = 0; m_idle = 0;
                sbq.delete();
            end else begin
                e.pv = 0; e.err = 0; e.to = 0;
                if (!m_act) begin
                    if (sensor_vehicule) begin
                        m_act = 1; m_dig.delete(); m_idle = 0;
                    end
                end else if (!sensor_vehicule) begin
                    m_act = 0; m_dig.delete(); m_pw = 0; m_idle = 0;
                end else if (key_valid) begin
                    m_idle = 0;
                    if (key_code <= 9) begin
                        if (m_dig.size() < 4) m_dig.push_back(int'(key_code));
                        else e.err = 1;
                    end else if (key_code == 4'hA) begin
                        m_dig.delete();
                    end else if (key_code == 4'hB) begin
                        if (m_dig.size() == 4) begin
                            v = 0;
                            foreach (m_dig[i]) v = v * 16 + m_dig[i];
                            m_pw = v;
                            e.pv = 1;
                        end else begin
                            e.err = 1;
                        end
                        m_dig.delete();
                    end else begin
                        e.err = 1;
                    end
                end else if (m_dig.size() > 0) begin
                    m_idle++;
                    if (m_idle == T) begin
                        m_dig.delete(); m_idle = 0; e.to = 1;
                    end
                end
                e.pw = 16'(m_pw);
                e.dc = 3'(m_dig.size());
                sbq.push_back(e);
            end
        end
    end

    // Monitor: every output is registered, so one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sbq.size() > 0) begin
                e = sbq.pop_front();
                n_chk++;
                if (password_input === e.pw && pin_valid === e.pv &&
                    digit_count === e.dc && entry_error === e.err &&
                    entry_timeout === e.to) begin
                    n_pass++;
                    if (pin_valid) n_pins++;
                end else begin
                    $display("FAIL cycle_outputs t=%0t got pw=%h pv=%b dc=%0d err=%b to=%b want pw=%h pv=%b dc=%0d err=%b to=%b",
                             $time, password_input, pin_valid, digit_count, entry_error, entry_timeout,
                             e.pw, e.pv, e.dc, e.err, e.to);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        n_chk++;
        if (password_input === 16'h0 && pin_valid === 1'b0 && digit_count === 3'd0 &&
            entry_error === 1'b0 && entry_timeout === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL %s got pw=%h pv=%b dc=%0d err=%b to=%b want all zero",
                     name, password_input, pin_valid, digit_count, entry_error, entry_timeout);
        end
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        key_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int r;
        rst = 1'b1; sensor_vehicule = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        #1 check_zero("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-entry, asserted between edges.
        sensor_vehicule = 1'b1;
        idle(1);
        key(4'h3); key(4'h7);
        #2 rst = 1'b1;
        #1 check_zero("async_reset_mid_entry");
        @(negedge clk);
        #2 rst = 1'b0;
        idle(3);

        // Correct PIN, then hold.
        key(4'h3); key(4'h7); key(4'h6); key(4'h1); key(4'hB);
        idle(10);

        // Short entry, overflow digit, then ENTER.
        key(4'h1); key(4'h2); key(4'hB);
        key(4'h3); key(4'h7); key(4'h6); key(4'h1); key(4'h5); key(4'hB);
        idle(2);

        // Illegal key and CLEAR.
        key(4'h4); key(4'hE); key(4'h2); key(4'hA);
        key(4'h9); key(4'h9); key(4'h9); key(4'h9); key(4'hB);
        idle(2);

        // Timeout and the just-short-of-timeout case.
        key(4'h3); idle(T + 2);
        key(4'h3); idle(T - 1); key(4'h7); idle(T - 1); key(4'hA);

        // Sensor drop together with ENTER, then keys with sensor low.
        key(4'h3); key(4'h7); key(4'h6); key(4'h1);
        sensor_vehicule = 1'b0;
        key(4'hB);
        key(4'h5); key(4'hB); key(4'hF);
        sensor_vehicule = 1'b1;
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (sensor_vehicule) begin
                if ($urandom_range(0, 149) == 0) sensor_vehicule = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                sensor_vehicule = 1'b1;
            end
            r = $urandom_range(0, 99);
            if (r < 4) begin
                idle($urandom_range(T - 2, T + 2));
            end else if (r < 60) begin
                r = $urandom_range(0, 99);
                if (r < 75)      key(4'($urandom_range(0, 9)));
                else if (r < 88) key(4'hB);
                else if (r < 94) key(4'hA);
                else             key(4'($urandom_range(12, 15)));
            end else begin
                idle(1);
            end
        end

        idle(3);
        #1;
        n_chk++;
        if (n_pins > 0) n_pass++;
        else $display("FAIL pin_seen got %0d accepted PINs want at least 1", n_pins);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pin_keypad_collector.md
Name: pin_keypad_collector

Overview:
Upstream stage of controlador_estacionamiento. It collects single BCD keystrokes from the gate keypad and assembles them into the 16-bit password_input word, first digit in [15:12]. It emits a one-cycle pin_valid strobe when the user presses ENTER with exactly four digits. Entry is gated by sensor_vehicule and cleared on inactivity.

Parameters:
TIMEOUT_CYCLES, 1000, consecutive cycles with no keystroke before a partial entry is discarded (must be ≥2)
CNT_W, 10, width of the inactivity counter (2^CNT_W ≥ TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset
sensor_vehicule  in  1  vehicle present at gate; enables key entry
key_valid  in  1  one-cycle strobe: key_code is valid this cycle
key_code  in  4  0x0–0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC–0xF illegal
password_input  out  16  assembled BCD PIN; feeds the controller
pin_valid  out  1  one-cycle pulse: password_input holds a new 4-digit PIN
digit_count  out  3  digits currently buffered (0–4)
entry_error  out  1  one-cycle pulse on rejected key or short ENTER
entry_timeout  out  1  one-cycle pulse when a partial entry is discarded by inactivity

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset state:
  - All outputs are 0.
  - Internal buffer and inactivity counter are 0.
  - FSM is in IDLE.
- All outputs are registered. Pulses (pin_valid, entry_error, entry_timeout) assert the cycle after the causing strobe is sampled and last exactly one cycle.
- FSM states:
  - IDLE: keys are ignored with no error. sensor_vehicule=1 moves to COLLECT with buffer and digit_count cleared.
  - COLLECT: digit_count < 4.
    - Digit key: buffer = {buffer[11:0], key_code} and digit_count++. Reaching 4 moves to FULL.
  - FULL: digit_count = 4.
    - Digit key: ignored, entry_error pulses, buffer unchanged.
    - ENTER: password_input <= buffer, pin_valid pulses, buffer and digit_count clear, go to COLLECT.
- ENTER in COLLECT (fewer than 4 digits): entry_error pulses, no pin_valid, buffer and digit_count clear, stay in COLLECT.
- CLEAR in COLLECT/FULL: buffer and digit_count clear, go to COLLECT, no error.
- Illegal code 0xC–0xF: entry_error pulses, buffer and digit_count unchanged.
- password_input holds its value between ENTERs. It changes only on an accepted ENTER, on reset, or on sensor drop.
- Inactivity timeout:
  - The counter runs only in COLLECT/FULL with digit_count > 0.
  - Any key_valid resets it to 0.
  - On the TIMEOUT_CYCLES-th consecutive cycle without key_valid: buffer and digit_count clear, entry_timeout pulses, counter returns to 0, state goes to COLLECT.
- sensor_vehicule falling (sampled low in COLLECT/FULL):
  - Go to IDLE.
  - Buffer, digit_count, password_input and the counter clear to 0.
  - This has priority over a simultaneous ENTER, digit or timeout: no pin_valid and no error is produced that cycle.
- key_valid held high for several cycles counts as one key per cycle. Debouncing is upstream of this block.
- Reset asserted mid-entry: immediate return to the reset state. Any pending pulse is suppressed.
- No arithmetic beyond digit_count (saturates at 4) and the inactivity counter (never exceeds TIMEOUT_CYCLES).

Test Plan:
1. Reset mid-entry: sensor=1, keys 3,7, then rst=1 asynchronously between edges → all outputs 0 immediately, digit_count=0. After release, no pulses.
2. Correct PIN: sensor=1, keys 3,7,6,1,ENTER → digit_count 1..4. The cycle after ENTER: pin_valid=1 for one cycle, password_input=16'h3761, digit_count=0. password_input is still 16'h3761 ten cycles later.
3. Short entry and overflow:
   - Keys 1,2,ENTER → entry_error one cycle, no pin_valid, digit_count=0.
   - Then keys 3,7,6,1,5 → entry_error on the 5.
   - Then ENTER → password_input=16'h3761.
4. Illegal key and CLEAR:
   - Keys 4,0xE → entry_error, digit_count stays 1.
   - Then 2,CLEAR → digit_count=0, no error.
   - Then 9,9,9,9,ENTER → 16'h9999 with pin_valid.
5. Timeout (TIMEOUT_CYCLES=8): key 3, then 8 idle cycles → entry_timeout one cycle, digit_count=0. Keys 3,7 with 7 idle cycles between them → no timeout.
6. Sensor drop:
   - After 3,7,6,1, drop sensor_vehicule in the same cycle as ENTER → no pin_valid, password_input=0, FSM in IDLE.
   - Keys pressed while the sensor is low → ignored, no entry_error.
